// File: rtl/leak_serializer.sv
// Serialises one captured 64-bit leak word onto a single covert pin as a
// framed packet: preamble, data MSB-first, even parity, then an idle gap.
module leak_serializer #(
  parameter int               DATA_W   = 64,
  parameter int               PRE_W    = 8,
  parameter logic [PRE_W-1:0] PREAMBLE = 8'hA5,
  parameter int               DIV      = 4,
  parameter int               GAP_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_en,
  output logic              busy,
  output logic [7:0]        frame_cnt
);

  localparam int MAXB_A = (DATA_W > PRE_W) ? DATA_W : PRE_W;
  localparam int MAXB   = (MAXB_A > GAP_BITS) ? MAXB_A : GAP_BITS;
  localparam int CNT_W  = $clog2(MAXB + 1);

  typedef enum logic [2:0] {IDLE, PRE, DATA, PAR, GAP} state_t;

  state_t             state_q, state_d;
  logic [PRE_W-1:0]   preSr_q, preSr_d;
  logic [DATA_W-1:0]  dataSr_q, dataSr_d;
  logic               parity_q, parity_d;
  logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
  logic [7:0]         divCnt_q, divCnt_d;
  logic               txBit_q, txBit_d;
  logic               txEn_q, txEn_d;
  logic [7:0]         frameCnt_q, frameCnt_d;
  logic               bitDone;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      preSr_q    <= '0;
      dataSr_q   <= '0;
      parity_q   <= 1'b0;
      bitCnt_q   <= '0;
      divCnt_q   <= '0;
      txBit_q    <= 1'b0;
      txEn_q     <= 1'b0;
      frameCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      preSr_q    <= preSr_d;
      dataSr_q   <= dataSr_d;
      parity_q   <= parity_d;
      bitCnt_q   <= bitCnt_d;
      divCnt_q   <= divCnt_d;
      txBit_q    <= txBit_d;
      txEn_q     <= txEn_d;
      frameCnt_q <= frameCnt_d;
    end
  end

  assign bitDone = (divCnt_q == 8'(DIV - 1));

  always_comb begin
    state_d    = state_q;
    preSr_d    = preSr_q;
    dataSr_d   = dataSr_q;
    parity_d   = parity_q;
    bitCnt_d   = bitCnt_q;
    divCnt_d   = divCnt_q;
    frameCnt_d = frameCnt_q;

    // Divider runs in every non-idle state; IDLE keeps it parked at zero.
    if (state_q != IDLE) begin
      divCnt_d = bitDone ? 8'd0 : divCnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = PRE;
          preSr_d  = PREAMBLE;
          dataSr_d = in_data;
          parity_d = ^in_data;
          bitCnt_d = '0;
          divCnt_d = 8'd0;
        end
      end
      PRE: begin
        if (bitDone) begin
          if (bitCnt_q == CNT_W'(PRE_W - 1)) begin
            state_d  = DATA;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
            preSr_d  = preSr_q << 1;
          end
        end
      end
      DATA: begin
        if (bitDone) begin
          if (bitCnt_q == CNT_W'(DATA_W - 1)) begin
            state_d  = PAR;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
            dataSr_d = dataSr_q << 1;
          end
        end
      end
      PAR: begin
        if (bitDone) begin
          frameCnt_d = frameCnt_q + 8'd1;
          bitCnt_d   = '0;
          state_d    = (GAP_BITS == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (bitDone) begin
          if (bitCnt_q == CNT_W'(GAP_BITS - 1)) begin
            state_d  = IDLE;
            bitCnt_d = '0;
          end else begin
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin outputs are derived from next-state so they line up with the state edge.
    txEn_d  = (state_d == PRE) || (state_d == DATA) || (state_d == PAR);
    txBit_d = 1'b0;
    case (state_d)
      PRE:     txBit_d = preSr_d[PRE_W-1];
      DATA:    txBit_d = dataSr_d[DATA_W-1];
      PAR:     txBit_d = parity_d;
      default: txBit_d = 1'b0;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign tx_bit    = txBit_q;
  assign tx_en     = txEn_q;
  assign frame_cnt = frameCnt_q;

endmodule
